// File: rtl/led_pkg.sv
// Shared mode and direction encodings for the LED pattern engine.
package led_pkg;

   typedef enum logic [2:0] {
      MODE_OFF     = 3'd0,
      MODE_STATIC  = 3'd1,
      MODE_BLINK   = 3'd2,
      MODE_RUN     = 3'd3,
      MODE_BREATHE = 3'd4
   } mode_e;

   localparam logic DIR_LEFT  = 1'b0;
   localparam logic DIR_RIGHT = 1'b1;

endpackage

// File: rtl/led_prescaler.sv
// Base-tick generator: a registered one-clk pulse every TICK_DIV clocks.
module led_prescaler #(
   parameter int TICK_DIV = 50000
) (
   input  logic clk,
   input  logic rst,
   output logic tick
);

   localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

   logic [CW-1:0] cnt;

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt  <= '0;
         tick <= 1'b0;
      end else begin
         cnt  <= (cnt == LAST) ? '0 : cnt + CW'(1);
         tick <= (cnt == LAST);
      end
   end

endmodule

// File: rtl/led_pattern_ctrl.sv
// Multi-channel LED pattern engine: off/static/blink/run/breathe, configured
// through a valid/ready port whose request is committed on the next base tick.
module led_pattern_ctrl
   import led_pkg::*;
#(
   parameter int LED_NUM  = 4,
   parameter int TICK_DIV = 50000,
   parameter int PERIOD_W = 16,
   parameter int PWM_W    = 8
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                cfg_valid,
   output logic                cfg_ready,
   input  logic [2:0]          cfg_mode,
   input  logic                cfg_dir,
   input  logic [LED_NUM-1:0]  cfg_pattern,
   input  logic [PERIOD_W-1:0] cfg_period,
   output logic [LED_NUM-1:0]  led,
   output logic                tick,
   output logic                step
);

   localparam logic [PWM_W-1:0] DUTY_MAX = '1;

   led_prescaler #(.TICK_DIV(TICK_DIV)) u_prescaler (
      .clk  (clk),
      .rst  (rst),
      .tick (tick)
   );

   mode_e               sh_mode,    act_mode;
   logic                sh_dir,     act_dir;
   logic [LED_NUM-1:0]  sh_pattern, act_pattern;
   logic [PERIOD_W-1:0] sh_period,  act_period;
   logic                pending;
   logic [PERIOD_W-1:0] step_cnt;
   logic                phase;
   logic [LED_NUM-1:0]  work;
   logic [PWM_W-1:0]    pwm_cnt;
   logic [PWM_W-1:0]    duty;
   logic                duty_up;

   logic                accept, commit, step_hit;
   logic [PERIOD_W-1:0] last_idx;
   logic [LED_NUM-1:0]  work_rot, led_next;

   assign cfg_ready = ~pending;
   assign accept    = cfg_valid & cfg_ready;
   // Only a shadow captured before this tick can commit; pending excludes same-cycle captures.
   assign commit    = tick & pending;
   assign last_idx  = (act_period == '0) ? '0 : act_period - PERIOD_W'(1);
   assign step_hit  = tick & ~commit & (step_cnt >= last_idx);

   // NOTE: every combinational output gets a default first so no latch is inferred.
   always_comb begin
      work_rot = (work << 1) | (work >> (LED_NUM - 1));
      if (act_dir == DIR_RIGHT)
         work_rot = (work >> 1) | (work << (LED_NUM - 1));

      led_next = '0;
      case (act_mode)
         MODE_STATIC:  led_next = act_pattern;
         MODE_BLINK:   led_next = phase ? act_pattern : '0;
         MODE_RUN:     led_next = work;
         MODE_BREATHE: led_next = (pwm_cnt < duty) ? act_pattern : '0;
         default:      led_next = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sh_mode     <= MODE_OFF;
         sh_dir      <= DIR_LEFT;
         sh_pattern  <= '0;
         sh_period   <= PERIOD_W'(1);
         act_mode    <= MODE_OFF;
         act_dir     <= DIR_LEFT;
         act_pattern <= '0;
         act_period  <= PERIOD_W'(1);
         pending     <= 1'b0;
         step_cnt    <= '0;
         step        <= 1'b0;
         phase       <= 1'b1;
         work        <= '0;
         pwm_cnt     <= '0;
         duty        <= '0;
         duty_up     <= 1'b1;
         led         <= '0;
      end else begin
         pwm_cnt <= pwm_cnt + PWM_W'(1);
         step    <= step_hit;
         led     <= led_next;

         if (accept) begin
            sh_mode    <= (cfg_mode > MODE_BREATHE) ? MODE_OFF : mode_e'(cfg_mode);
            sh_dir     <= cfg_dir;
            sh_pattern <= cfg_pattern;
            sh_period  <= cfg_period;
            pending    <= 1'b1;
         end

         if (commit) begin
            act_mode    <= sh_mode;
            act_dir     <= sh_dir;
            act_pattern <= sh_pattern;
            act_period  <= sh_period;
            pending     <= 1'b0;
            step_cnt    <= '0;
            phase       <= 1'b1;
            work        <= sh_pattern;
            duty        <= '0;
            duty_up     <= 1'b1;
         end else if (step_hit) begin
            step_cnt <= '0;
            phase    <= ~phase;
            work     <= work_rot;
            // Duty bounces between the ends rather than wrapping.
            if (duty_up) begin
               if (duty == DUTY_MAX) begin
                  duty    <= duty - PWM_W'(1);
                  duty_up <= 1'b0;
               end else begin
                  duty <= duty + PWM_W'(1);
               end
            end else if (duty == '0) begin
               duty    <= duty + PWM_W'(1);
               duty_up <= 1'b1;
            end else begin
               duty <= duty - PWM_W'(1);
            end
         end else if (tick) begin
            step_cnt <= step_cnt + PERIOD_W'(1);
         end
      end
   end

endmodule
